// File: rtl/match_scheduler_pkg.sv
// Shared types and frame constants for the binary template-matching controller.
package match_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned COLS    = 40;
    localparam int unsigned ROWS    = 100;
    localparam int unsigned THRESH  = 3600;
    localparam int unsigned XMAX    = 639;
    localparam int unsigned YMAX    = 479;
    localparam int unsigned SCORE_W = 12;
    localparam int unsigned HIT_W   = 16;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned CNT_W   = 6;

    // Side-band fields carried alongside the column score through stage 1.
    typedef struct packed {
        logic             valid;
        logic             mark;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } col_tag_t;

endpackage

// File: rtl/match_scheduler_col_popcount.sv
// Stage 1: XNOR popcount of one template/image column pair, registered when enabled.
module match_scheduler_col_popcount
    import match_scheduler_pkg::*;
#(
    parameter int unsigned N     = ROWS,
    parameter int unsigned OUT_W = COL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     tarray,
    input  logic [N-1:0]     iarray,
    output logic [OUT_W-1:0] col_score
);

    logic [N-1:0]     match_bits;
    logic [OUT_W-1:0] count_c;

    assign match_bits = ~(tarray ^ iarray);

    always_comb begin
        count_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            count_c = count_c + OUT_W'(match_bits[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_score <= '0;
        end else if (en) begin
            col_score <= count_c;
        end
    end

endmodule

// File: rtl/match_scheduler.sv
// Frame controller: drives the line buffer, accumulates 40-column window scores,
// tracks the best window and hit count, and hands the result to the host.
module match_scheduler
    import match_scheduler_pkg::*;
#(
    parameter int unsigned COLS   = match_scheduler_pkg::COLS,
    parameter int unsigned ROWS   = match_scheduler_pkg::ROWS,
    parameter int unsigned THRESH = match_scheduler_pkg::THRESH,
    parameter int unsigned XMAX   = match_scheduler_pkg::XMAX,
    parameter int unsigned YMAX   = match_scheduler_pkg::YMAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic               lb_ena,
    input  logic               lb_valid,
    input  logic [POS_W-1:0]   lb_xpos,
    input  logic [POS_W-1:0]   lb_ypos,
    input  logic               lb_mark,
    input  logic [ROWS-1:0]    tarray,
    input  logic [ROWS-1:0]    iarray,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ack,
    output logic [SCORE_W-1:0] best_score,
    output logic [POS_W-1:0]   best_x,
    output logic [POS_W-1:0]   best_y,
    output logic [HIT_W-1:0]   hit_count
);

    state_t state;
    state_t next_state;

    logic sampled_c;
    logic frame_end_c;
    logic start_c;
    logic flush_cnt;

    col_tag_t         s1_tag;
    logic             s1_vld;
    logic [COL_W-1:0] col_score;

    logic [SCORE_W-1:0] acc;
    logic [CNT_W-1:0]   col_cnt;
    logic               allvalid;

    logic close_c;
    logic eligible_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (start)       next_state = ST_RUN;
            ST_RUN:   if (frame_end_c) next_state = ST_FLUSH;
            ST_FLUSH: if (flush_cnt)   next_state = ST_DONE;
            ST_DONE:  if (result_ack)  next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    // Line-buffer enable is only released while running and not held
    always_comb begin
        lb_ena = 1'b1;
        if (state == ST_RUN) begin
            lb_ena = hold;
        end
    end

    assign sampled_c   = ~lb_ena;
    assign frame_end_c = sampled_c && (lb_xpos == POS_W'(XMAX)) && (lb_ypos == POS_W'(YMAX));
    assign start_c     = (state == ST_IDLE) && start;

    // Two-cycle drain: first cycle retires the last column, second closes the trailing window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt <= 1'b0;
        end else begin
            flush_cnt <= (state == ST_FLUSH) && !flush_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (next_state == ST_RUN) || (next_state == ST_FLUSH);
            result_valid <= (next_state == ST_DONE);
        end
    end

    match_scheduler_col_popcount #(
        .N     (ROWS),
        .OUT_W (COL_W)
    ) u_col_popcount (
        .clk       (clk),
        .rst       (rst),
        .en        (sampled_c),
        .tarray    (tarray),
        .iarray    (iarray),
        .col_score (col_score)
    );

    // Stage-1 side-band; s1_vld marks a fresh column for exactly one stage-2 cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld <= 1'b0;
            s1_tag <= '0;
        end else begin
            s1_vld <= sampled_c;
            if (sampled_c) begin
                s1_tag <= '{valid: lb_valid, mark: lb_mark, x: lb_xpos, y: lb_ypos};
            end
        end
    end

    assign close_c    = (s1_vld && s1_tag.mark) || ((state == ST_FLUSH) && flush_cnt);
    assign eligible_c = close_c && (col_cnt == CNT_W'(COLS)) && allvalid;

    // Stage 2: window accumulation and best/hit tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            col_cnt    <= '0;
            allvalid   <= 1'b0;
            best_score <= '0;
            best_x     <= '0;
            best_y     <= '0;
            hit_count  <= '0;
        end else if (start_c) begin
            acc        <= '0;
            col_cnt    <= '0;
            allvalid   <= 1'b0;
            best_score <= '0;
            best_x     <= '0;
            best_y     <= '0;
            hit_count  <= '0;
        end else if (close_c) begin
            if (eligible_c && (acc > best_score)) begin
                best_score <= acc;
                best_x     <= s1_tag.x;
                best_y     <= s1_tag.y;
            end
            if (eligible_c && (acc >= SCORE_W'(THRESH)) && (hit_count != '1)) begin
                hit_count <= hit_count + HIT_W'(1);
            end
            if (s1_vld) begin
                acc      <= SCORE_W'(col_score);
                col_cnt  <= CNT_W'(1);
                allvalid <= s1_tag.valid;
            end else begin
                acc      <= '0;
                col_cnt  <= '0;
                allvalid <= 1'b0;
            end
        end else if (s1_vld) begin
            acc      <= acc + SCORE_W'(col_score);
            col_cnt  <= (col_cnt == '1) ? col_cnt : col_cnt + CNT_W'(1);
            allvalid <= allvalid & s1_tag.valid;
        end
    end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler on a reduced 120x3 frame with a column-level scoreboard.
module tb_match_scheduler;
    import match_scheduler_pkg::*;

    localparam int unsigned TB_XMAX = 119;
    localparam int unsigned TB_YMAX = 2;
    localparam int unsigned W       = TB_XMAX + 1;
    localparam int unsigned NCOL    = W * (TB_YMAX + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               hold = 1'b0;
    logic               lb_ena;
    logic               lb_valid = 1'b0;
    logic [POS_W-1:0]   lb_xpos = '0;
    logic [POS_W-1:0]   lb_ypos = '0;
    logic               lb_mark = 1'b0;
    logic [ROWS-1:0]    tarray = '0;
    logic [ROWS-1:0]    iarray = '0;
    logic               busy;
    logic               result_valid;
    logic               result_ack = 1'b0;
    logic [SCORE_W-1:0] best_score;
    logic [POS_W-1:0]   best_x;
    logic [POS_W-1:0]   best_y;
    logic [HIT_W-1:0]   hit_count;

    match_scheduler #(
        .COLS   (40),
        .ROWS   (ROWS),
        .THRESH (3600),
        .XMAX   (TB_XMAX),
        .YMAX   (TB_YMAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .hold         (hold),
        .lb_ena       (lb_ena),
        .lb_valid     (lb_valid),
        .lb_xpos      (lb_xpos),
        .lb_ypos      (lb_ypos),
        .lb_mark      (lb_mark),
        .tarray       (tarray),
        .iarray       (iarray),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .best_score   (best_score),
        .best_x       (best_x),
        .best_y       (best_y),
        .hit_count    (hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score;
        int x;
        int y;
        int hits;
    } exp_t;

    exp_t            sbq[$];
    logic [ROWS-1:0] ta[NCOL];
    logic [ROWS-1:0] ia[NCOL];
    logic            va[NCOL];
    logic            ma[NCOL];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] rand_col();
        return ROWS'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    // Column-level reference: windows delimited by marks, closed once more at frame end
    task automatic model_push();
        exp_t e;
        int acc = 0, cnt = 0, s;
        bit allv = 0;
        e = '{0, 0, 0, 0};
        for (int i = 0; i <= int'(NCOL); i++) begin
            if (i == int'(NCOL) || ma[i]) begin
                int ci = (i == int'(NCOL)) ? i - 1 : i;
                if (cnt == 40 && allv) begin
                    if (acc > e.score) begin
                        e.score = acc;
                        e.x = ci % int'(W);
                        e.y = ci / int'(W);
                    end
                    if (acc >= 3600) e.hits++;
                end
                if (i == int'(NCOL)) break;
                acc = 0; cnt = 0; allv = va[i];
            end else begin
                allv = allv & va[i];
            end
            s = $countones(~(ta[i] ^ ia[i]));
            acc += s;
            cnt++;
        end
        sbq.push_back(e);
    endtask

    task automatic fill_base(input int kind);
        for (int i = 0; i < int'(NCOL); i++) begin
            ma[i] = ((i % int'(W)) % 40) == 5;
            va[i] = 1'b1;
            if (kind == 0) begin
                ta[i] = '1;
                ia[i] = '1;
            end else if (kind == 1) begin
                ta[i] = rand_col();
                ia[i] = ~ta[i];
            end else begin
                ta[i] = rand_col();
                ia[i] = rand_col();
            end
        end
    endtask

    task automatic perfect_window(input int close_idx);
        for (int i = close_idx - 40; i < close_idx; i++) ia[i] = ta[i];
    endtask

    // Acts as the line buffer: presents column idx and advances when lb_ena is low
    task automatic run_cols(input int ncols, input int hold_at, input int hold_len, output bit hold_ok);
        int idx = 0, held = 0, guard = 0;
        hold_ok = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        while (idx < ncols && guard < 5000) begin
            lb_xpos  = POS_W'(idx % int'(W));
            lb_ypos  = POS_W'(idx / int'(W));
            lb_mark  = ma[idx];
            lb_valid = va[idx];
            tarray   = ta[idx];
            iarray   = ia[idx];
            hold     = (idx == hold_at) && (held < hold_len);
            #1;
            if (hold) begin
                held++;
                if (lb_ena !== 1'b1) hold_ok = 1'b0;
            end else if (lb_ena === 1'b0) begin
                idx++;
            end
            @(negedge clk);
            guard++;
        end
        hold = 1'b0;
        lb_mark = 1'b0;
        lb_xpos = '0;
        lb_ypos = '0;
        check("columns_consumed", 32'(idx), 32'(ncols));
    endtask

    task automatic wait_and_check(input string tag);
        exp_t e;
        int k = 0;
        while (result_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_result_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        if (sbq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_best_score"}, 32'(best_score), 32'(e.score));
            check({tag, "_best_x"},     32'(best_x),     32'(e.x));
            check({tag, "_best_y"},     32'(best_y),     32'(e.y));
            check({tag, "_hit_count"},  32'(hit_count),  32'(e.hits));
        end
    endtask

    task automatic do_ack(input string tag);
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        check({tag, "_valid_after_ack"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        bit ok;
        logic [SCORE_W-1:0] s_bs;
        logic [HIT_W-1:0]   s_hc;
        logic [POS_W-1:0]   s_bx, s_by;
        bit stable;

        repeat (3) @(negedge clk);
        check("rst_lb_ena",       32'(lb_ena),       32'd1);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_best_score",   32'(best_score),   32'd0);
        check("rst_hit_count",    32'(hit_count),    32'd0);
        rst = 1'b1;
        @(negedge clk);

        // All-matching frame: every full window scores 4000
        fill_base(0);
        model_push();
        run_cols(NCOL, -1, 0, ok);
        wait_and_check("all_match");
        do_ack("all_match");

        // Exactly one perfect window, closed by the mark at column 205
        fill_base(1);
        perfect_window(205);
        model_push();
        run_cols(NCOL, -1, 0, ok);
        wait_and_check("single_window");
        do_ack("single_window");

        // All-matching frame with a 50-cycle stall mid-window
        fill_base(0);
        model_push();
        run_cols(NCOL, 60, 50, ok);
        check("hold_lb_ena_high", 32'(ok), 32'd1);
        wait_and_check("hold");
        do_ack("hold");

        // Random frame; the only perfect window carries one invalid column
        fill_base(2);
        perfect_window(125);
        va[100] = 1'b0;
        model_push();
        run_cols(NCOL, -1, 0, ok);
        wait_and_check("invalid_col");
        check("invalid_col_not_4000", 32'(best_score != 12'd4000), 32'd1);
        do_ack("invalid_col");

        // Result held in DONE for 100 cycles, start pulsed and ignored
        fill_base(2);
        model_push();
        run_cols(NCOL, -1, 0, ok);
        wait_and_check("done_hold");
        s_bs = best_score; s_bx = best_x; s_by = best_y; s_hc = hit_count;
        stable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            start = (c == 50);
            @(negedge clk);
            if (best_score !== s_bs || best_x !== s_bx || best_y !== s_by ||
                hit_count !== s_hc || result_valid !== 1'b1 || busy !== 1'b0)
                stable = 1'b0;
        end
        start = 1'b0;
        check("done_stable", 32'(stable), 32'd1);
        do_ack("done_hold");

        // Reset in the middle of a run with a partially accumulated window
        fill_base(0);
        run_cols(60, -1, 0, ok);
        rst = 1'b0;
        #1;
        check("midrst_lb_ena",       32'(lb_ena),       32'd1);
        check("midrst_busy",         32'(busy),         32'd0);
        check("midrst_result_valid", 32'(result_valid), 32'd0);
        check("midrst_best_score",   32'(best_score),   32'd0);
        check("midrst_hit_count",    32'(hit_count),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lb_ena_next", 32'(lb_ena), 32'd1);

        // Fresh frame after reset still works
        fill_base(0);
        model_push();
        run_cols(NCOL, -1, 0, ok);
        wait_and_check("after_reset");
        do_ack("after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
